// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer and memory handshake for the 8-bit accumulator CPU.
// Optional single-step mode is compiled in with `define CPU_CTRL_STEP_EN.
module cpu_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef CPU_CTRL_STEP_EN
    input  logic       stepReq,
`endif
    input  logic [1:0] opcode,
    input  logic       memRdy,
    output logic       pass,
    output logic       add,
    output logic       ldAc,
    output logic       ldIr,
    output logic       incPc,
    output logic       ldPc,
    output logic       irOnAdr,
    output logic       pcOnAdr,
    output logic       rdMem,
    output logic       wrMem,
    output logic       memErr
);

    typedef enum logic [2:0] {
        RST,
        FETCH,
        DECODE,
        EX_LDA,
        EX_STA,
        EX_ADD,
        EX_JMP
`ifdef CPU_CTRL_STEP_EN
        ,
        STEP_WAIT
`endif
    } state_t;

`ifdef CPU_CTRL_STEP_EN
    localparam state_t AFTER_EX = STEP_WAIT;
`else
    localparam state_t AFTER_EX = FETCH;
`endif

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] waitCnt;
    logic       memState;
    logic       timedOut;
    logic       waiting;

    assign memState = (state == FETCH) || (state == EX_LDA) || (state == EX_STA);
    assign timedOut = memState && !memRdy && (waitCnt == LAST_WAIT);
    assign waiting  = memState && !memRdy && !timedOut;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RST;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            // Counter only survives consecutive wait cycles; any exit clears it.
            waitCnt <= waiting ? waitCnt + 8'd1 : 8'd0;
            if (timedOut) begin
                memErr <= 1'b1;
            end
            unique case (state)
                RST: state <= AFTER_EX;
                FETCH: begin
                    if (memRdy) begin
                        state <= DECODE;
                    end else if (timedOut) begin
                        state <= FETCH;
                    end
                end
                DECODE: begin
                    unique case (opcode)
                        2'b00: state <= EX_LDA;
                        2'b01: state <= EX_STA;
                        2'b10: state <= EX_ADD;
                        2'b11: state <= EX_JMP;
                        default: state <= RST;
                    endcase
                end
                EX_LDA, EX_STA: begin
                    if (memRdy || timedOut) begin
                        state <= AFTER_EX;
                    end
                end
                EX_ADD, EX_JMP: state <= AFTER_EX;
`ifdef CPU_CTRL_STEP_EN
                STEP_WAIT: begin
                    if (stepReq) begin
                        state <= FETCH;
                    end
                end
`endif
                default: state <= RST;
            endcase
        end
    end

    always_comb begin
        pass    = 1'b0;
        add     = 1'b0;
        ldAc    = 1'b0;
        ldIr    = 1'b0;
        incPc   = 1'b0;
        ldPc    = 1'b0;
        irOnAdr = 1'b0;
        pcOnAdr = 1'b0;
        rdMem   = 1'b0;
        wrMem   = 1'b0;
        unique case (state)
            FETCH: begin
                pcOnAdr = 1'b1;
                rdMem   = 1'b1;
                ldIr    = memRdy;
                incPc   = memRdy;
            end
            EX_LDA: begin
                irOnAdr = 1'b1;
                rdMem   = 1'b1;
                ldAc    = memRdy;
            end
            EX_STA: begin
                irOnAdr = 1'b1;
                pass    = 1'b1;
                wrMem   = 1'b1;
            end
            EX_ADD: begin
                add  = 1'b1;
                ldAc = 1'b1;
            end
            EX_JMP: ldPc = 1'b1;
            default: ;
        endcase
    end

endmodule
